// File: rtl/input_conditioner_pkg.sv
// Shared constants, types and helpers for the input conditioner.
// The optional debouncer is enabled by defining INPUT_CONDITIONER_DEBOUNCE_EN.
package input_conditioner_pkg;

  localparam int DEF_NUM_INPUTS      = 4;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;

  // Qualified outputs of one channel, bundled so the top can fan them out.
  typedef struct packed {
    logic pressed;
    logic press_pulse;
    logic release_pulse;
  } chan_out_t;

  // Debounce counter width: it only has to reach DEBOUNCE_CYCLES-1, and it
  // is never narrower than one bit so a single-cycle window still elaborates.
  function automatic int cnt_width(input int debounce_cycles);
    int w;
    w = $clog2(debounce_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/input_channel.sv
// One conditioned input: synchroniser, optional debouncer, press/release pulses.
// The debouncer exists only when INPUT_CONDITIONER_DEBOUNCE_EN is defined;
// otherwise the synchronised level is accepted on the following edge.
module input_channel
  import input_conditioner_pkg::*;
#(
  parameter int   SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      raw_i,
  output chan_out_t out_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   sync_active;   // synchronised level, 1 = not idle
  logic                   accept;        // take the synchronised level this edge

  logic pressed_q, pressed_d;
  logic press_pulse_q, press_pulse_d;
  logic release_pulse_q, release_pulse_d;

  assign sync_d      = {sync_q[SYNC_STAGES-2:0], raw_i};
  assign sync_active = sync_q[SYNC_STAGES-1] ^ IDLE_LEVEL;

  // Synchroniser chain; resets to the idle level so reset never looks like an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: registers are written with <= so every flop samples pre-edge values;
    // blocking assignments here would collapse the synchroniser into one stage.
    if (rst_i) sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
    else       sync_q <= sync_d;
  end

`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
  localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive edges at a new level; any agreeing edge restarts the count.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    cnt_d  = cnt_q;
    accept = 1'b0;
    if (sync_active == pressed_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_TERM) begin
      accept = 1'b1;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  // Without debouncing, any disagreement is accepted on the next edge.
  assign accept = (sync_active != pressed_q);
`endif

  // Next debounced state and the edge pulses that accompany a change.
  always_comb begin
    pressed_d       = pressed_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    if (accept) begin
      pressed_d       = sync_active;
      press_pulse_d   = sync_active;
      release_pulse_d = ~sync_active;
    end
  end

  // Debounced state and pulse registers; pulses land in the same cycle as the change.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
    end else begin
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
    end
  end

  assign out_o.pressed       = pressed_q;
  assign out_o.press_pulse   = press_pulse_q;
  assign out_o.release_pulse = release_pulse_q;

endmodule

// File: rtl/input_conditioner.sv
// Input conditioner top: NUM_INPUTS independent channels plus a combined event flag.
// Debouncing is compiled in when INPUT_CONDITIONER_DEBOUNCE_EN is defined.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int                    NUM_INPUTS      = DEF_NUM_INPUTS,
  parameter int                    SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int                    DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic [NUM_INPUTS-1:0] IDLE_LEVEL      = '1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_INPUTS-1:0] raw_in_i,
  output logic [NUM_INPUTS-1:0] pressed_o,
  output logic [NUM_INPUTS-1:0] press_pulse_o,
  output logic [NUM_INPUTS-1:0] release_pulse_o,
  output logic                  any_event_o
);

  chan_out_t chan_out [NUM_INPUTS];

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_chan
    input_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IDLE_LEVEL     (IDLE_LEVEL[i])
    ) u_chan (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .raw_i (raw_in_i[i]),
      .out_o (chan_out[i])
    );

    assign pressed_o[i]       = chan_out[i].pressed;
    assign press_pulse_o[i]   = chan_out[i].press_pulse;
    assign release_pulse_o[i] = chan_out[i].release_pulse;
  end

  // Pulses are registered per channel, so the OR is a clean one-cycle flag.
  assign any_event_o = |(press_pulse_o | release_pulse_o);

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner. Works in both builds: the
// debounced build uses SYNC_STAGES=2, the plain build SYNC_STAGES=3.
`timescale 1ns/1ps
module tb_input_conditioner;

  localparam int NI  = 4;
  localparam int DEB = 16;
`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
  localparam int SYNC   = 2;
  localparam bit DEB_EN = 1'b1;
`else
  localparam int SYNC   = 3;
  localparam bit DEB_EN = 1'b0;
`endif
  localparam int              WIN  = DEB_EN ? DEB : 1;  // edges a new level must persist
  localparam int              LAT  = SYNC + WIN;         // edge at which Pressed changes
  localparam logic [NI-1:0]   IDLE = '1;
  localparam int              MAXE = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic [NI-1:0] raw_in;
  logic [NI-1:0] pressed, pp, rp;
  logic          any_event;

  int checks   = 0;
  int failures = 0;
  int event_cnt = 0;
  int ev0;

  always #5 clk = ~clk;

  input_conditioner #(
    .NUM_INPUTS(NI), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .IDLE_LEVEL(IDLE)
  ) dut (
    .clk_i(clk), .rst_i(rst), .raw_in_i(raw_in),
    .pressed_o(pressed), .press_pulse_o(pp), .release_pulse_o(rp),
    .any_event_o(any_event)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Raw level recorded at every edge since reset; the synchronised level after
  // edge m is the raw level sampled SYNC-1 edges earlier (idle before reset).
  logic [NI-1:0] raw_hist [MAXE];
  int            m_n;
  logic [NI-1:0] m_lvl;   // accepted pad level per channel
  logic [NI-1:0] m_pp, m_rp;

  function automatic logic [NI-1:0] s_at(input int m);
    if (m - SYNC + 1 >= 1) return raw_hist[(m - SYNC + 1) % MAXE];
    return IDLE;
  endfunction

  // A channel accepts at edge n when the synchronised level differed from the
  // accepted level on each of the WIN edges before n.
  function automatic logic [NI-1:0] accept_at(input int n);
    logic [NI-1:0] acc = '1;
    for (int k = 1; k <= WIN; k++) acc &= s_at(n - k) ^ m_lvl;
    return acc;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n   <= 0;
      m_lvl <= IDLE;
      m_pp  <= '0;
      m_rp  <= '0;
    end else begin
      m_n                       <= m_n + 1;
      raw_hist[(m_n + 1) % MAXE] <= raw_in;
      m_lvl <= m_lvl ^ accept_at(m_n + 1);
      m_pp  <= accept_at(m_n + 1) &  ((m_lvl ^ accept_at(m_n + 1)) ^ IDLE);
      m_rp  <= accept_at(m_n + 1) & ~((m_lvl ^ accept_at(m_n + 1)) ^ IDLE);
    end
  end

  // Compare every cycle on the falling edge, away from the active edge.
  always @(negedge clk) begin
    check("cyc_pressed", pressed,   m_lvl ^ IDLE);
    check("cyc_press",   pp,        m_pp);
    check("cyc_release", rp,        m_rp);
    check("cyc_any",     any_event, |(m_pp | m_rp));
    if (any_event === 1'b1) event_cnt++;
  end

  // Advance k rising edges, then settle 1 ns past the last one.
  task automatic edges(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst    = 1'b1;
    raw_in = IDLE;
    edges(3);
    check("rst_pressed", pressed, 0);
    check("rst_any", any_event, 0);
    rst = 1'b0;

    // Idle for 100 cycles: nothing may happen.
    ev0 = event_cnt;
    edges(100);
    check("idle_events", event_cnt - ev0, 0);
    check("idle_pressed", pressed, 0);

    // Reset mid-qualification on ch0, with ch3 held active through reset.
    raw_in[0] = 1'b0;
    edges(LAT / 2);
    rst = 1'b1;
    #1;
    check("midrst_pressed", pressed, 0);
    check("midrst_pulse", pp | rp, 0);
    raw_in[0] = 1'b1;
    raw_in[3] = 1'b0;
    edges(1);
    rst = 1'b0;
    edges(LAT - 1);
    check("held_pre_pressed", pressed, 4'b0000);
    edges(1);
    check("held_pressed", pressed, 4'b1000);
    check("held_press_pulse", pp, 4'b1000);
    edges(20);
    check("midrst_no_ch0", pressed, 4'b1000);

    // Ch0 press: changes exactly at edge LAT (18 with defaults).
    raw_in[0] = 1'b0;
    edges(LAT - 1);
    check("ch0_pre_pressed", pressed, 4'b1000);
    check("ch0_pre_pulse", pp, 4'b0000);
    edges(1);
    check("ch0_pressed", pressed, 4'b1001);
    check("ch0_press_pulse", pp, 4'b0001);
    check("ch0_any", any_event, 1);
    edges(1);
    check("ch0_pulse_gone", pp, 4'b0000);
    check("ch0_any_gone", any_event, 0);

`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
    // Ch1 bounce: low 10, high 2, then low held; accepted at edge 30.
    ev0 = event_cnt;
    raw_in[1] = 1'b0;
    edges(10);
    raw_in[1] = 1'b1;
    edges(2);
    raw_in[1] = 1'b0;
    edges(17);
    check("bounce_events", event_cnt - ev0, 0);
    check("bounce_pre_pressed", pressed, 4'b1001);
    edges(1);
    check("bounce_pressed", pressed, 4'b1011);
    check("bounce_press_pulse", pp, 4'b0010);
`else
    // Ch1 one-cycle glitch: press at edge 4, release at edge 5.
    raw_in[1] = 1'b0;
    edges(1);
    raw_in[1] = 1'b1;
    edges(3);
    check("glitch_press_pulse", pp, 4'b0010);
    check("glitch_pressed", pressed, 4'b1011);
    edges(1);
    check("glitch_release_pulse", rp, 4'b0010);
    check("glitch_released", pressed, 4'b1001);
`endif

    // Ch2 press then release.
    raw_in[2] = 1'b0;
    edges(LAT + 3);
    check("ch2_pressed", pressed[2], 1);
    raw_in[2] = 1'b1;
    edges(LAT - 1);
    check("ch2_rel_pre", pressed[2], 1);
    check("ch2_rel_pre_pulse", rp[2], 0);
    edges(1);
    check("ch2_released", pressed[2], 0);
    check("ch2_release_pulse", rp[2], 1);
    check("ch2_no_press_pulse", pp[2], 0);
    edges(1);
    check("ch2_release_gone", rp[2], 0);

    // Release ch0 and ch3 together, then press them together.
    raw_in[0] = 1'b1;
    raw_in[3] = 1'b1;
    edges(LAT);
    check("dual_release", rp & 4'b1001, 4'b1001);
    edges(3);
    check("dual_idle", pressed & 4'b1001, 4'b0000);
    ev0 = event_cnt;
    raw_in[0] = 1'b0;
    raw_in[3] = 1'b0;
    edges(LAT);
    check("dual_press", pp, 4'b1001);
    check("dual_any", any_event, 1);
    edges(1);
    check("dual_any_gone", any_event, 0);
    edges(2);
    check("dual_single_event", event_cnt - ev0, 1);

    // Reset while channels are pressed clears everything immediately.
    rst = 1'b1;
    #1;
    check("rst_while_pressed", pressed, 0);
    raw_in = IDLE;
    edges(2);
    rst = 1'b0;
    edges(LAT + 5);
    check("final_pressed", pressed, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
